// File: rtl/twos_to_signmag_serial_pkg.sv
// Shared types and constants for the serial two's-complement to sign-magnitude decoder.
package twos_signmag_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/twos_to_signmag_serial_if.sv
// Input word and output result handshakes of the serial sign-magnitude decoder.
interface twos_to_signmag_serial_if
    import twos_signmag_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_sign;
    logic [WIDTH-1:0] out_mag;
    logic             out_min;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sign, out_mag, out_min
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sign, out_mag, out_min
    );
endinterface

// File: rtl/twos_to_signmag_serial_negate_bit.sv
// One-bit serial negator: pass bits through the first one, invert every bit after it.
module serial_negate_bit (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic neg,
    input  logic b,
    output logic res_c
);
    logic seen_one_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            seen_one_q <= 1'b0;
        end else if (en && neg && !seen_one_q) begin
            seen_one_q <= b;
        end
    end

    assign res_c = (neg && seen_one_q) ? ~b : b;
endmodule

// File: rtl/twos_to_signmag_serial.sv
// Bit-serial two's-complement to sign-magnitude decoder with valid/ready on both sides.
module twos_to_signmag_serial
    import twos_signmag_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    twos_to_signmag_serial_if.slave    bus,
    output logic                       busy
);
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-2:0] mag_q;
    logic             sign_q;

    logic             in_ready_q, out_valid_q, busy_q;
    logic             out_sign_q, out_min_q;
    logic [WIDTH-1:0] out_mag_q;

    logic             accept_c, shift_c, last_c, res_c;
    logic [WIDTH-1:0] mag_next_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        accept_c   = 1'b0;
        shift_c    = 1'b0;
        last_c     = 1'b0;
        mag_next_c = {res_c, mag_q};
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    accept_c = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                shift_c = 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    last_c  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    serial_negate_bit u_negate (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept_c),
        .en    (shift_c),
        .neg   (sign_q),
        .b     (shreg_q[0]),
        .res_c (res_c)
    );

    // Result bits enter at the top so the first (LSB) bit lands in bit 0 after WIDTH shifts.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_sign_q  <= 1'b0;
            out_mag_q   <= '0;
            out_min_q   <= 1'b0;
            cnt_q       <= '0;
            shreg_q     <= '0;
            mag_q       <= '0;
            sign_q      <= 1'b0;
        end else begin
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
            if (accept_c) begin
                shreg_q <= bus.in_data;
                sign_q  <= bus.in_data[WIDTH-1];
                cnt_q   <= '0;
                mag_q   <= '0;
            end
            if (shift_c) begin
                shreg_q <= shreg_q >> 1;
                mag_q   <= mag_next_c[WIDTH-1:1];
                cnt_q   <= cnt_q + CNT_W'(1);
            end
            if (last_c) begin
                out_sign_q <= sign_q;
                out_mag_q  <= mag_next_c;
                out_min_q  <= sign_q & (mag_next_c == MIN_MAG);
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sign  = out_sign_q;
    assign bus.out_mag   = out_mag_q;
    assign bus.out_min   = out_min_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_twos_to_signmag_serial.sv
// Bench for twos_to_signmag_serial: behavioural transaction model plus directed literal checks.
module tb_twos_to_signmag_serial;
    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    twos_to_signmag_serial_if #(.WIDTH(W)) bus ();

    twos_to_signmag_serial #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Model: phase 0 idle, 1 converting, 2 result pending
    int         m_phase = 0;
    int         m_left  = 0;
    logic [W-1:0] m_word = '0;
    logic         m_sign = 1'b0;
    logic [W-1:0] m_mag  = '0;
    logic         m_min  = 1'b0;
    int accepts  = 0;
    int cyc      = 0;
    int last_acc = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_phase  = 0;
            m_sign   = 1'b0;
            m_mag    = '0;
            m_min    = 1'b0;
            last_acc = -1;
        end else begin
            case (m_phase)
                0: if (bus.in_valid) begin
                    m_word  = bus.in_data;
                    m_left  = W;
                    m_phase = 1;
                    accepts++;
                    if (chk_en && last_acc >= 0) begin
                        checks++;
                        if (cyc - last_acc < W + 2) begin
                            failures++;
                            $display("FAIL accept_gap: got %0d cycles expected >= %0d", cyc - last_acc, W + 2);
                        end
                    end
                    last_acc = cyc;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_sign  = m_word[W-1];
                        m_mag   = m_sign ? W'(-m_word) : m_word;
                        m_min   = m_sign && (m_mag == W'(1 << (W - 1)));
                        m_phase = 2;
                    end
                end
                default: if (bus.out_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",  32'(bus.in_ready),  32'(m_phase == 0));
            chk("out_valid", 32'(bus.out_valid), 32'(m_phase == 2));
            chk("busy",      32'(busy),          32'(m_phase != 0));
            chk("out_sign",  32'(bus.out_sign),  32'(m_sign));
            chk("out_mag",   32'(bus.out_mag),   32'(m_mag));
            chk("out_min",   32'(bus.out_min),   32'(m_min));
        end
    end

    task automatic wait_accept(input int acc0);
        int n = 0;
        while (accepts == acc0 && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_timeout", 32'(accepts != acc0), 32'd1);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        chk("valid_timeout", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic run_word(input logic [W-1:0] d, input logic es, input logic [W-1:0] em,
                            input logic emin, input int hold);
        int acc0 = accepts;
        int n;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.out_ready = (hold == 0);
        wait_accept(acc0);
        bus.in_valid = 1'b0;
        wait_valid(n);
        chk("latency", 32'(n), 32'(W));
        chk("lit_sign", 32'(bus.out_sign), 32'(es));
        chk("lit_mag",  32'(bus.out_mag),  32'(em));
        chk("lit_min",  32'(bus.out_min),  32'(emin));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_mag",   32'(bus.out_mag),   32'(em));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("ready_back", 32'(bus.in_ready), 32'd1);
        chk("valid_drop", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int acc0;
        int n;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy",      32'(busy),          32'd0);
        chk("rst_mag",       32'(bus.out_mag),   32'd0);
        chk_en = 1'b1;

        run_word(4'b0101, 1'b0, 4'b0101, 1'b0, 0);
        run_word(4'b1011, 1'b1, 4'b0101, 1'b0, 0);
        run_word(4'b1111, 1'b1, 4'b0001, 1'b0, 1);
        run_word(4'b1100, 1'b1, 4'b0100, 1'b0, 0);
        run_word(4'b1000, 1'b1, 4'b1000, 1'b1, 2);
        run_word(4'b0000, 1'b0, 4'b0000, 1'b0, 0);

        // Backpressure with a second word offered while busy
        acc0 = accepts;
        bus.in_valid = 1'b1;
        bus.in_data  = 4'b0110;
        bus.out_ready = 1'b0;
        wait_accept(acc0);
        bus.in_data = 4'b0011;
        wait_valid(n);
        chk("bp_mag", 32'(bus.out_mag), 32'd6);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid",    32'(bus.out_valid), 32'd1);
            chk("bp_in_ready", 32'(bus.in_ready),  32'd0);
            chk("bp_mag_hold", 32'(bus.out_mag),   32'd6);
            chk("bp_no_take",  32'(accepts),       32'(acc0 + 1));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        chk("bp_next_accept", 32'(accepts), 32'(acc0 + 2));
        bus.in_valid = 1'b0;
        wait_valid(n);
        chk("bp2_mag",  32'(bus.out_mag),  32'd3);
        chk("bp2_sign", 32'(bus.out_sign), 32'd0);
        @(posedge clk); #1;

        // Reset during the second conversion cycle
        acc0 = accepts;
        bus.in_valid = 1'b1;
        bus.in_data  = 4'b1010;
        bus.out_ready = 1'b1;
        wait_accept(acc0);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_busy",      32'(busy),          32'd0);
        chk("mid_rst_sign",      32'(bus.out_sign),  32'd0);
        chk("mid_rst_mag",       32'(bus.out_mag),   32'd0);
        chk("mid_rst_min",       32'(bus.out_min),   32'd0);
        repeat (3) @(posedge clk);
        #1;
        run_word(4'b1010, 1'b1, 4'b0110, 1'b0, 0);

        // All 16 words back to back with random downstream stalls
        for (int w = 0; w < 16; w++) begin
            int k = 0;
            acc0 = accepts;
            bus.in_valid = 1'b1;
            bus.in_data  = W'(w);
            while (accepts == acc0 && k < 400) begin
                @(negedge clk);
                bus.out_ready = 1'($urandom_range(0, 1));
                k++;
            end
            chk("sweep_accept", 32'(accepts != acc0), 32'd1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (busy !== 1'b0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
